// File: rtl/miss_refill_arbiter_pkg.sv
// rtl/miss_refill_arbiter_pkg.sv - shared types and constants for the miss refill arbiter
package mips_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Clears the byte-in-line offset; beats must be a power of two.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                    input int beats);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(beats * 4) - ADDR_W'(1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/miss_refill_arbiter_if.sv
// rtl/miss_refill_arbiter_if.sv - miss request, cache fill and backing-memory signal bundle
interface miss_refill_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int IDX_W = $clog2(BEATS)
) ();

    logic              i_miss;
    logic [ADDR_W-1:0] i_addr;
    logic              i_fill_we;
    logic [IDX_W-1:0]  i_fill_idx;
    logic              i_done;

    logic              d_miss;
    logic [ADDR_W-1:0] d_addr;
    logic              d_dirty;
    logic [ADDR_W-1:0] d_victim_addr;
    logic [IDX_W-1:0]  d_wb_idx;
    logic [DATA_W-1:0] d_wb_data;
    logic              d_fill_we;
    logic [IDX_W-1:0]  d_fill_idx;
    logic              d_done;

    logic [DATA_W-1:0] fill_data;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, d_dirty, d_victim_addr, d_wb_data,
               mem_ack, mem_rdata,
        output i_fill_we, i_fill_idx, i_done, d_wb_idx, d_fill_we, d_fill_idx, d_done,
               fill_data, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, d_dirty, d_victim_addr, d_wb_data,
               mem_ack, mem_rdata,
        input  i_fill_we, i_fill_idx, i_done, d_wb_idx, d_fill_we, d_fill_idx, d_done,
               fill_data, mem_req, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/miss_refill_arbiter_line_beat_seq.sv
// rtl/miss_refill_arbiter_line_beat_seq.sv - beat counter and per-beat word address for line transfers
module line_beat_seq
    import mips_mem_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic [IDX_W-1:0]  beat_o,
    output logic              last_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [IDX_W-1:0] beat_q, beat_d;

    // Clear has priority so the final ack of a phase leaves the counter at 0.
    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (advance_i) begin
            beat_d = beat_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == IDX_W'(BEATS - 1));
    assign addr_o = base_i + ADDR_W'({beat_q, 2'b00});

endmodule

// File: rtl/miss_refill_arbiter.sv
// rtl/miss_refill_arbiter.sv - arbitrates I/D cache misses onto one backing-memory port with writeback and refill
module miss_refill_arbiter
    import mips_mem_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    miss_refill_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(BEATS);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] victim_q, victim_d;
    logic              fill_we_q, fill_we_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              grant_d;

    logic              active;
    logic              beat_clear;
    logic              beat_adv;
    logic              last_beat;
    logic [IDX_W-1:0]  beat;
    logic [ADDR_W-1:0] seq_base;
    logic [ADDR_W-1:0] seq_addr;

    assign active     = (state_q == WB) || (state_q == FILL);
    assign beat_clear = (state_d != state_q);
    assign beat_adv   = active && bus.mem_ack;
    assign seq_base   = (state_q == WB) ? victim_q : base_q;

    line_beat_seq #(.BEATS(BEATS), .IDX_W(IDX_W)) u_seq (
        .clk_i     (Clk),
        .rst_ni    (Rst),
        .clear_i   (beat_clear),
        .advance_i (beat_adv),
        .base_i    (seq_base),
        .beat_o    (beat),
        .last_o    (last_beat),
        .addr_o    (seq_addr)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        base_d       = base_q;
        victim_d     = victim_q;
        fill_we_d    = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        grant_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_miss || bus.d_miss) begin
                    // D wins a tie unless it owned the port last time.
                    grant_d  = bus.d_miss && (!bus.i_miss || (last_owner_q == OWN_I));
                    owner_d  = grant_d ? OWN_D : OWN_I;
                    base_d   = line_base(grant_d ? bus.d_addr : bus.i_addr, BEATS);
                    victim_d = line_base(bus.d_victim_addr, BEATS);
                    state_d  = (grant_d && bus.d_dirty) ? WB : FILL;
                end
            end
            WB: begin
                if (bus.mem_ack && last_beat) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (bus.mem_ack) begin
                    fill_we_d   = 1'b1;
                    fill_idx_d  = beat;
                    fill_data_d = bus.mem_rdata;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            base_q       <= '0;
            victim_q     <= '0;
            fill_we_q    <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            base_q       <= base_d;
            victim_q     <= victim_d;
            fill_we_q    <= fill_we_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign bus.mem_req    = active;
    assign bus.mem_we     = (state_q == WB);
    assign bus.mem_addr   = active ? seq_addr : '0;
    assign bus.mem_wdata  = (state_q == WB) ? bus.d_wb_data : '0;
    assign bus.d_wb_idx   = (state_q == WB) ? beat : '0;

    assign bus.i_fill_we  = fill_we_q && (owner_q == OWN_I);
    assign bus.d_fill_we  = fill_we_q && (owner_q == OWN_D);
    assign bus.i_fill_idx = bus.i_fill_we ? fill_idx_q : '0;
    assign bus.d_fill_idx = bus.d_fill_we ? fill_idx_q : '0;
    assign bus.fill_data  = fill_data_q;

    assign bus.i_done     = (state_q == DONE) && (owner_q == OWN_I);
    assign bus.d_done     = (state_q == DONE) && (owner_q == OWN_D);
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_miss_refill_arbiter.sv
// tb/tb_miss_refill_arbiter.sv - self-checking bench for miss_refill_arbiter
module tb_miss_refill_arbiter;
    import mips_mem_pkg::*;

    localparam int BEATS = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    miss_refill_arbiter_if #(.BEATS(BEATS)) bus ();

    miss_refill_arbiter #(.BEATS(BEATS)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] wb_model(input int idx);
        return 32'hDA7A_0000 + 32'(idx) * 32'h111;
    endfunction

    assign bus.d_wb_data = wb_model(int'(bus.d_wb_idx));

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { bit side; int idx; logic [31:0] data; } fill_t;

    beat_t exp_beat_q[$];
    fill_t exp_fill_q[$];
    bit    exp_done_q[$];

    task automatic expect_service(input bit side, input logic [31:0] addr,
                                  input bit dirty, input logic [31:0] victim);
        logic [31:0] base, vbase;
        base  = addr & ~(32'(BEATS * 4) - 32'd1);
        vbase = victim & ~(32'(BEATS * 4) - 32'd1);
        if (dirty) begin
            for (int k = 0; k < BEATS; k++)
                exp_beat_q.push_back('{1'b1, vbase + 32'(k * 4), wb_model(k)});
        end
        for (int k = 0; k < BEATS; k++) begin
            exp_beat_q.push_back('{1'b0, base + 32'(k * 4), 32'd0});
            exp_fill_q.push_back('{side, k, rd_model(base + 32'(k * 4))});
        end
        exp_done_q.push_back(side);
    endtask

    // Memory responder plus output monitors, all evaluated away from the active edge.
    int          wait_cnt = 0;
    int          base_lat = 1;
    bit          hold_en  = 1'b0;
    int          fills_seen = 0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    bit          prev_we  = 1'b0;
    logic [31:0] prev_addr = '0;
    int          lat;
    beat_t       eb;
    fill_t       ef;
    bit          ed;

    always @(negedge Clk) begin
        if (bus.i_fill_we || bus.d_fill_we) begin
            fills_seen++;
            if (exp_fill_q.size() == 0) begin
                check("unexpected_fill", 1, 0);
            end else begin
                ef = exp_fill_q.pop_front();
                check("fill_side", {bus.d_fill_we, bus.i_fill_we}, ef.side ? 2'b10 : 2'b01);
                check("fill_idx", ef.side ? bus.d_fill_idx : bus.i_fill_idx, ef.idx);
                check("fill_data", bus.fill_data, ef.data);
            end
        end
        if (bus.i_done || bus.d_done) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                ed = exp_done_q.pop_front();
                check("done_side", {bus.d_done, bus.i_done}, ed ? 2'b10 : 2'b01);
                check("done_with_last_fill",
                      ed ? {bus.d_fill_we, bus.d_fill_idx} : {bus.i_fill_we, bus.i_fill_idx},
                      {1'b1, 2'(BEATS - 1)});
            end
        end
        if (bus.mem_req && prev_req && !prev_ack)
            check("beat_hold", {bus.mem_we, bus.mem_addr}, {prev_we, prev_addr});
        if (bus.mem_req && Rst) begin
            lat = (hold_en && bus.mem_addr[3:2] == 2'd1) ? 5 : base_lat;
            if (wait_cnt >= lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rd_model(bus.mem_addr);
                wait_cnt      = 0;
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    eb = exp_beat_q.pop_front();
                    check("beat_we", bus.mem_we, eb.we);
                    check("beat_addr", bus.mem_addr, eb.addr);
                    if (eb.we) check("beat_wdata", bus.mem_wdata, eb.wdata);
                end
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            wait_cnt      = 0;
        end
        prev_req  = bus.mem_req;
        prev_ack  = bus.mem_ack;
        prev_we   = bus.mem_we;
        prev_addr = bus.mem_addr;
    end

    task automatic run_services(input int budget);
        int cyc = 0;
        while ((bus.i_miss || bus.d_miss || bus.busy) && cyc < budget) begin
            @(negedge Clk);
            if (bus.i_done) bus.i_miss = 1'b0;
            if (bus.d_done) bus.d_miss = 1'b0;
            cyc++;
        end
        check("service_timeout", cyc >= budget, 0);
        check("beats_left", exp_beat_q.size(), 0);
        check("fills_left", exp_fill_q.size(), 0);
        check("dones_left", exp_done_q.size(), 0);
    endtask

    typedef struct {
        bit im; logic [31:0] ia;
        bit dm; logic [31:0] da; bit dirty; logic [31:0] va;
        int lat; bit d_first;
    } vec_t;
    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0124, 1'b0, 32'h0,         1'b0, 32'h0,         2, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0810, 1'b1, 32'h0000_0400, 1, 1'b1};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0810, 1'b0, 32'h0,         0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_2000, 1'b1, 32'h0000_3004, 1'b1, 32'h0000_5008, 1, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0040, 1'b0, 32'h0,         1'b0, 32'h0,         0, 1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_077C, 1'b0, 32'h0,         1, 1'b1};

        bus.i_miss = 1'b1; bus.i_addr = 32'h0000_0900;
        bus.d_miss = 1'b1; bus.d_addr = 32'h0000_0A40;
        bus.d_dirty = 1'b0; bus.d_victim_addr = 32'h0;
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_ctrl", {bus.mem_req, bus.mem_we, bus.busy, bus.i_fill_we, bus.d_fill_we,
                             bus.i_done, bus.d_done, bus.d_wb_idx}, 0);
        check("reset_bus", bus.mem_addr | bus.mem_wdata | bus.fill_data, 0);

        // last_owner resets to I, so a tie goes to D first.
        expect_service(1'b1, 32'h0000_0A40, 1'b0, 32'h0);
        expect_service(1'b0, 32'h0000_0900, 1'b0, 32'h0);
        base_lat = 1;
        Rst = 1'b1;
        run_services(200);

        for (int v = 0; v < 6; v++) begin
            @(negedge Clk);
            base_lat          = vecs[v].lat;
            bus.i_addr        = vecs[v].ia;
            bus.d_addr        = vecs[v].da;
            bus.d_dirty       = vecs[v].dirty;
            bus.d_victim_addr = vecs[v].va;
            if (vecs[v].im && vecs[v].dm) begin
                if (vecs[v].d_first) begin
                    expect_service(1'b1, vecs[v].da, vecs[v].dirty, vecs[v].va);
                    expect_service(1'b0, vecs[v].ia, 1'b0, 32'h0);
                end else begin
                    expect_service(1'b0, vecs[v].ia, 1'b0, 32'h0);
                    expect_service(1'b1, vecs[v].da, vecs[v].dirty, vecs[v].va);
                end
            end else if (vecs[v].dm) begin
                expect_service(1'b1, vecs[v].da, vecs[v].dirty, vecs[v].va);
            end else begin
                expect_service(1'b0, vecs[v].ia, 1'b0, 32'h0);
            end
            bus.i_miss = vecs[v].im;
            bus.d_miss = vecs[v].dm;
            run_services(300);
        end

        // Beat 1 ack withheld for 5 cycles; the monitor checks address/we stability.
        @(negedge Clk);
        base_lat = 1; hold_en = 1'b1;
        bus.i_addr = 32'h0000_0700;
        expect_service(1'b0, 32'h0000_0700, 1'b0, 32'h0);
        bus.i_miss = 1'b1;
        run_services(200);
        hold_en = 1'b0;

        // Reset after two fill beats; the held miss must restart from beat 0.
        @(negedge Clk);
        base_lat = 2;
        bus.i_addr = 32'h0000_0340;
        expect_service(1'b0, 32'h0000_0340, 1'b0, 32'h0);
        bus.i_miss = 1'b1;
        begin
            int start, cyc;
            start = fills_seen;
            cyc = 0;
            while (fills_seen < start + 2 && cyc < 100) begin
                @(negedge Clk);
                cyc++;
            end
            check("reset_mid_timeout", cyc >= 100, 0);
        end
        Rst = 1'b0;
        @(negedge Clk);
        check("reset_mid_idle", {bus.mem_req, bus.busy, bus.i_done, bus.d_done,
                                 bus.i_fill_we, bus.d_fill_we}, 0);
        exp_beat_q.delete();
        exp_fill_q.delete();
        exp_done_q.delete();
        expect_service(1'b0, 32'h0000_0340, 1'b0, 32'h0);
        Rst = 1'b1;
        run_services(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
